// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared types and helpers for the multi-channel switch debouncer.
//   - db_state_t : per-channel filter state. The LO_* states give db=0 and
//                  the HI_* states give db=1.
//   - cnt_width  : width of the per-channel stability counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        LO_STABLE,
        LO_TO_HI,
        HI_STABLE,
        HI_TO_LO
    } db_state_t;

    // The counter holds 0 .. stable_cycles-1. It is kept at least one bit
    // wide, which covers the smallest legal stable_cycles value of 2.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
//   One debouncer channel: synchroniser, stability filter FSM with counter,
//   registered rise/fall pulses and a sticky change flag.
// Ports:
//   clk      in  system clock (rising edge)
//   reset    in  asynchronous active-high reset
//   sw       in  raw asynchronous switch input
//   evt_clr  in  clears evt on the next edge (a new change on that edge wins)
//   db       out debounced level
//   db_rise  out one-cycle pulse in the first cycle that db reads 1
//   db_fall  out one-cycle pulse in the first cycle that db reads 0
//   evt      out sticky flag, set whenever db changes
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic evt_clr,
    output logic db,
    output logic db_rise,
    output logic db_fall,
    output logic evt
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam db_state_t RESET_STATE = RESET_LEVEL ? HI_STABLE : LO_STABLE;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sw_s;
    db_state_t              r_state;
    db_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   r_db;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_evt;

    // Synchroniser: the filter only ever sees the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw};
        end
    end

    assign w_sw_s = r_sync[SYNC_STAGES-1];

    // The counter records how many consecutive samples have disagreed with
    // db so far. The edge that brings it to STABLE_CYCLES is the acceptance
    // edge, so it never holds more than STABLE_CYCLES-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            LO_STABLE: begin
                w_cnt_nxt = '0;
                if (w_sw_s) begin
                    w_state_nxt = LO_TO_HI;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            LO_TO_HI: begin
                if (!w_sw_s) begin
                    w_state_nxt = LO_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HI_STABLE;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HI_STABLE: begin
                w_cnt_nxt = '0;
                if (!w_sw_s) begin
                    w_state_nxt = HI_TO_LO;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            HI_TO_LO: begin
                if (w_sw_s) begin
                    w_state_nxt = HI_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = LO_STABLE;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RESET_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // db is registered from the next state so that it and the pulses change
    // on the same edge and come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
            r_db    <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= (w_state_nxt == HI_STABLE) || (w_state_nxt == HI_TO_LO);
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            // A change on this edge takes priority over a clear.
            if (w_rise_nxt || w_fall_nxt) begin
                r_evt <= 1'b1;
            end else if (evt_clr) begin
                r_evt <= 1'b0;
            end
        end
    end

    assign db      = r_db;
    assign db_rise = r_rise;
    assign db_fall = r_fall;
    assign evt     = r_evt;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
//   N_CH independent switch debouncers. Each channel is synchronised and then
//   filtered so that db only changes after STABLE_CYCLES consecutive agreeing
//   samples. Each channel also provides rise/fall pulses and a sticky,
//   clearable change flag.
// Ports:
//   clk      in  system clock (rising edge)
//   reset    in  asynchronous active-high reset
//   sw       in  [N_CH] raw asynchronous switch inputs
//   evt_clr  in  [N_CH] per-channel clear of evt
//   db       out [N_CH] debounced levels
//   db_rise  out [N_CH] one-cycle pulse when db goes 0->1
//   db_fall  out [N_CH] one-cycle pulse when db goes 1->0
//   evt      out [N_CH] sticky change flags
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   N_CH          = 4,
    parameter int   STABLE_CYCLES = 16,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic [N_CH-1:0] evt
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .sw      (sw[g]),
            .evt_clr (evt_clr[g]),
            .db      (db[g]),
            .db_rise (db_rise[g]),
            .db_fall (db_fall[g]),
            .evt     (evt[g])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

    localparam int N_CH          = 4;
    localparam int STABLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] evt_clr;
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] db_rise;
    logic [N_CH-1:0] db_fall;
    logic [N_CH-1:0] evt;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_multi #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .evt_clr (evt_clr),
        .db      (db),
        .db_rise (db_rise),
        .db_fall (db_fall),
        .evt     (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sw seen through a SYNC_STAGES-deep delay line, and a
    // run-length of consecutive samples that disagree with the debounced level.
    logic [N_CH-1:0] m_pipe [SYNC_STAGES];
    int              m_run  [N_CH];
    logic [N_CH-1:0] m_db, m_rise, m_fall, m_evt;

    always @(posedge clk or posedge reset) begin
        logic [N_CH-1:0] sws;
        logic            chg;
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_pipe[k] = '0;
            for (int c = 0; c < N_CH; c++) m_run[c] = 0;
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            m_evt  = '0;
        end else begin
            sws    = m_pipe[SYNC_STAGES-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N_CH; c++) begin
                chg = 1'b0;
                if (sws[c] !== m_db[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == STABLE_CYCLES) begin
                        m_run[c] = 0;
                        m_db[c]  = sws[c];
                        chg      = 1'b1;
                        if (sws[c]) m_rise[c] = 1'b1;
                        else        m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (chg) m_evt[c] = 1'b1;
                else if (evt_clr[c]) m_evt[c] = 1'b0;
            end
            for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = sw;
        end
    end

    // Every cycle, on the falling edge, compare all outputs with the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_db",      32'(db),      32'(m_db));
            check("model_db_rise", 32'(db_rise), 32'(m_rise));
            check("model_db_fall", 32'(db_fall), 32'(m_fall));
            check("model_evt",     32'(evt),     32'(m_evt));
            check("rise_fall_excl", 32'(db_rise & db_fall), 32'(0));
        end
    end

    int hold [N_CH];

    initial begin
        sw      = '0;
        evt_clr = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_db",   32'(db),      32'(0));
        check("reset_rise", 32'(db_rise), 32'(0));
        check("reset_evt",  32'(evt),     32'(0));

        // Async reset partway through a ch0 count, then a full count after it.
        sw[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rst_db",   32'(db),      32'(0));
        check("async_rst_rise", 32'(db_rise), 32'(0));
        check("async_rst_fall", 32'(db_fall), 32'(0));
        check("async_rst_evt",  32'(evt),     32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (e <= 5) check("ch0_before_edge6", 32'(db[0]), 32'(0));
            if (e == 6) begin
                check("ch0_db_edge6",   32'(db[0]),      32'(1));
                check("ch0_rise_edge6", 32'(db_rise[0]), 32'(1));
            end
            if (e == 7) begin
                check("ch0_rise_edge7", 32'(db_rise[0]), 32'(0));
                check("ch0_evt_edge7",  32'(evt[0]),     32'(1));
            end
        end

        // ch1 pulse of 3 samples: rejected.
        @(negedge clk);
        sw[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sw[1] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("ch1_short_db",  32'(db[1]),  32'(0));
            check("ch1_short_evt", 32'(evt[1]), 32'(0));
        end

        // ch1 pulse of 4 samples: accepted, then released; clear on the fall
        // edge loses to the set, a clear on its own then takes effect.
        @(negedge clk);
        sw[1] = 1'b1;
        repeat (4) @(posedge clk);
        for (int e = 5; e <= 11; e++) begin
            @(negedge clk);
            if (e == 5) sw[1] = 1'b0;
            evt_clr = (e >= 10) ? 4'b0010 : 4'b0000;
            @(posedge clk);
            #1;
            if (e == 6) begin
                check("ch1_db_edge6",   32'(db[1]),      32'(1));
                check("ch1_rise_edge6", 32'(db_rise[1]), 32'(1));
            end
            if (e == 9) check("ch1_db_edge9", 32'(db[1]), 32'(1));
            if (e == 10) begin
                check("ch1_db_edge10",   32'(db[1]),      32'(0));
                check("ch1_fall_edge10", 32'(db_fall[1]), 32'(1));
                check("ch1_evt_set_wins", 32'(evt[1]),    32'(1));
            end
            if (e == 11) begin
                check("ch1_evt_cleared", 32'(evt[1]),     32'(0));
                check("ch1_fall_edge11", 32'(db_fall[1]), 32'(0));
            end
        end
        @(negedge clk);
        evt_clr = '0;

        // Randomised chatter on all channels, with clears and rare resets.
        for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 10);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                hold[c] = hold[c] - 1;
                if (hold[c] <= 0) begin
                    sw[c]   = ~sw[c];
                    hold[c] = $urandom_range(1, 10);
                end
                evt_clr[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 599) == 0) begin
                @(posedge clk);
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel switch debouncer, the successor to the single-channel sw/db debouncer. Each of N_CH raw inputs is synchronised, then filtered by a per-channel state machine that requires STABLE_CYCLES consecutive agreeing samples before the debounced level changes. Adds per-channel single-cycle rise/fall pulses and sticky, software-clearable change flags. It sits between board pins and the control logic; the existing debounce_intf bench style (driver/monitor clocking blocks) extends to it by vector width.

Parameters:
N_CH, 4, number of independent channels (>=1)
STABLE_CYCLES, 16, consecutive synchronised samples required to accept a new level (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
RESET_LEVEL, 1'b0, reset value of synchroniser flops and db (idle switch level)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
sw  input  N_CH  raw, asynchronous switch inputs
evt_clr  input  N_CH  per-channel clear of evt, sampled on clk
db  output  N_CH  debounced level
db_rise  output  N_CH  one-cycle pulse, db went 0->1
db_fall  output  N_CH  one-cycle pulse, db went 1->0
evt  output  N_CH  sticky flag, set on any db change

Behaviour:
- Reset (async assert, release synchronous to clk): sync flops and db = RESET_LEVEL; FSM = LO_STABLE if RESET_LEVEL=0 else HI_STABLE; counters = 0; db_rise, db_fall, evt = 0. Reset mid-filtering discards any partial count.
- Synchroniser: sw_s[i] = sw[i] delayed SYNC_STAGES edges. There is no other use of raw sw.
- Per-channel FSM states: LO_STABLE, LO_TO_HI, HI_STABLE, HI_TO_LO. db=1 in HI_STABLE and HI_TO_LO.
  - LO_STABLE: sw_s=1 -> LO_TO_HI, cnt=1 (if STABLE_CYCLES would be met, see below). Else hold, cnt=0.
  - LO_TO_HI: sw_s=0 -> LO_STABLE, cnt=0 (glitch rejected, no pulse). sw_s=1 and cnt=STABLE_CYCLES-1 -> HI_STABLE, cnt=0, db_rise=1 for the next cycle. Else cnt++.
  - HI_STABLE / HI_TO_LO: mirror image, with db_fall.
- Counter width CNT_W = $clog2(STABLE_CYCLES). Never exceeds STABLE_CYCLES-1 and never wraps.
- Acceptance: sw_s must differ from db on exactly STABLE_CYCLES consecutive edges, counting the first differing edge. A level held for STABLE_CYCLES-1 sampled cycles is rejected.
- Latency: for a clean step, db changes on rising edge number SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples the new sw level as edge 1.
- db_rise/db_fall are registered. Each is high for exactly the one cycle in which db first shows its new value, and never both high in the same channel.
- evt[i]: set on the edge where db[i] changes. Cleared on the edge where evt_clr[i]=1. When set and clear occur on the same edge, set wins. evt_clr to an already-clear flag has no effect.
- Channels are fully independent. Simultaneous events on different channels are processed in parallel with no interaction.

Decomposition:
- Package debounce_pkg: enum typedef db_state_t {LO_STABLE, LO_TO_HI, HI_STABLE, HI_TO_LO}, and a function to compute CNT_W.
- Sub-module debounce_chan, one channel containing synchroniser, FSM, counter, pulse and evt logic. debounce_multi instantiates N_CH of these in a generate loop.

Test Plan (N_CH=4, STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0):
1. Assert reset asynchronously mid-count on ch0 -> db=4'b0000, db_rise=db_fall=evt=0 with no clock edge. After release, ch0 needs a full 4-sample stable count again.
2. sw[0] 0->1 before edge 1, held -> db[0]=1 from edge 6. db_rise[0]=1 for exactly that one cycle. evt[0]=1 and remains 1.
3. sw[1] high for 3 cycles then low -> db[1] stays 0, no pulses, evt[1]=0. Repeat with 4 cycles high -> db[1] rises at edge 6, then falls 6 edges after sw[1] returns low, with one db_fall[1] pulse.
4. sw[0] chatter 1,0,1,1,0,1,1,1,1 after db[0]=1 release attempt -> db[0] stays 1 until 4 consecutive low samples. Exactly one db_fall[0] pulse.
5. evt_clr[0]=1 on the same edge as a db[0] change -> evt[0] stays 1. evt_clr[0]=1 alone -> evt[0]=0 on the next edge.
6. sw[2] and sw[3] rise on the same edge, sw[3] drops after 2 cycles -> db[2] rises at edge 6. db[3], db_rise[3] and evt[3] stay 0.
